// File: rtl/iic_wr_master.sv
// Write-only I2C master: START, {DEV_ADDR,W}, control byte, data byte(s), STOP.
// SCL is push-pull; SDA is open-drain (sda_oe=1 pulls low).
module iic_wr_master #(
   parameter int         CLK_FRE  = 50,
   parameter int         IIC_FREQ = 400,
   parameter logic [6:0] DEV_ADDR = 7'h3C
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       send_en,
   input  logic [7:0] send_addr,
   input  logic [7:0] send_data,
   output logic       send_busy,
   input  logic       brust_vaild,
   output logic       brust_ready,
   output logic       scl,
   output logic       sda_o,
   output logic       sda_oe,
   input  logic       sda_i,
   output logic       ack_err
);
   localparam int          QDIV  = (CLK_FRE * 1000) / (IIC_FREQ * 4);
   localparam logic [15:0] QLAST = 16'(QDIV - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_SHIFT, S_ACK, S_REQ, S_STOP} state_t;

   state_t      r_state, w_state_nxt;
   logic [15:0] r_cnt;
   logic [1:0]  r_q, w_q_nxt;
   logic [2:0]  r_bit, w_bit_nxt;
   logic [1:0]  r_idx, w_idx_nxt;
   logic [1:0]  r_req, w_req_nxt;
   logic        r_nack;
   logic [7:0]  r_ctl, r_dat;
   logic        w_tick, w_ack_samp, w_nack, w_load, w_burst_load;
   logic [7:0]  w_byte;
   logic        w_scl_nxt, w_oe_nxt;
   logic        r_scl, r_oe, r_busy, r_ready, r_ack_err;

   assign w_tick     = (r_cnt == QLAST);
   assign w_ack_samp = (r_state == S_ACK) && (r_q == 2'd3) && (r_cnt == 16'd0);
   assign w_nack     = w_ack_samp ? sda_i : r_nack;

   always_comb begin
      w_state_nxt  = r_state;
      w_q_nxt      = r_q;
      w_bit_nxt    = r_bit;
      w_idx_nxt    = r_idx;
      w_req_nxt    = 2'd0;
      w_load       = 1'b0;
      w_burst_load = 1'b0;
      case (r_state)
         S_IDLE: if (send_en) begin
            w_state_nxt = S_START;
            w_q_nxt     = 2'd0;
            w_bit_nxt   = 3'd0;
            w_idx_nxt   = 2'd0;
            w_load      = 1'b1;
         end
         S_START: if (w_tick) begin
            if (r_q == 2'd1) begin
               w_state_nxt = S_SHIFT;
               w_q_nxt     = 2'd0;
            end else w_q_nxt = r_q + 2'd1;
         end
         S_SHIFT: if (w_tick) begin
            if (r_q == 2'd3) begin
               w_q_nxt = 2'd0;
               if (r_bit == 3'd7) begin
                  w_bit_nxt   = 3'd0;
                  w_state_nxt = S_ACK;
               end else w_bit_nxt = r_bit + 3'd1;
            end else w_q_nxt = r_q + 2'd1;
         end
         S_ACK: if (w_tick) begin
            if (r_q == 2'd3) begin
               w_q_nxt = 2'd0;
               if (w_nack) w_state_nxt = S_STOP;
               else if (r_idx < 2'd2) begin
                  w_idx_nxt   = r_idx + 2'd1;
                  w_state_nxt = S_SHIFT;
               end else if (brust_vaild) w_state_nxt = S_REQ;
               else w_state_nxt = S_STOP;
            end else w_q_nxt = r_q + 2'd1;
         end
         // Three-cycle handshake: ready at the first cycle, decision on the third.
         S_REQ: begin
            w_req_nxt = r_req + 2'd1;
            if (r_req == 2'd2) begin
               w_req_nxt = 2'd0;
               if (brust_vaild) begin
                  w_state_nxt  = S_SHIFT;
                  w_burst_load = 1'b1;
               end else w_state_nxt = S_STOP;
            end
         end
         S_STOP: if (w_tick) begin
            if (r_q == 2'd2) begin
               w_state_nxt = S_IDLE;
               w_q_nxt     = 2'd0;
            end else w_q_nxt = r_q + 2'd1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Pin levels are decoded from the next state so they register glitch-free.
   always_comb begin
      if (w_burst_load)          w_byte = send_data;
      else if (w_idx_nxt == 2'd0) w_byte = {DEV_ADDR, 1'b0};
      else if (w_idx_nxt == 2'd1) w_byte = r_ctl;
      else                        w_byte = r_dat;
      w_scl_nxt = 1'b1;
      w_oe_nxt  = 1'b0;
      case (w_state_nxt)
         S_START: w_oe_nxt = (w_q_nxt == 2'd1);
         S_SHIFT: begin
            w_scl_nxt = w_q_nxt[1];
            w_oe_nxt  = ~w_byte[3'd7 - w_bit_nxt];
         end
         S_ACK:   w_scl_nxt = w_q_nxt[1];
         S_REQ:   w_scl_nxt = 1'b0;
         S_STOP: begin
            w_scl_nxt = (w_q_nxt != 2'd0);
            w_oe_nxt  = (w_q_nxt != 2'd2);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= 16'd0;
         r_q       <= 2'd0;
         r_bit     <= 3'd0;
         r_idx     <= 2'd0;
         r_req     <= 2'd0;
         r_nack    <= 1'b0;
         r_scl     <= 1'b1;
         r_oe      <= 1'b0;
         r_busy    <= 1'b0;
         r_ready   <= 1'b0;
         r_ack_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= (r_state == S_IDLE || r_state == S_REQ || w_tick) ? 16'd0 : r_cnt + 16'd1;
         r_q       <= w_q_nxt;
         r_bit     <= w_bit_nxt;
         r_idx     <= w_idx_nxt;
         r_req     <= w_req_nxt;
         r_nack    <= w_nack;
         r_scl     <= w_scl_nxt;
         r_oe      <= w_oe_nxt;
         r_busy    <= (w_state_nxt != S_IDLE);
         r_ready   <= (w_state_nxt == S_REQ) && (r_state != S_REQ);
         r_ack_err <= w_ack_samp & sda_i;
      end
   end

   always_ff @(posedge clk) begin
      if (w_load) begin
         r_ctl <= send_addr;
         r_dat <= send_data;
      end else if (w_burst_load) begin
         r_dat <= send_data;
      end
   end

   assign scl         = r_scl;
   assign sda_o       = 1'b0;
   assign sda_oe      = r_oe;
   assign send_busy   = r_busy;
   assign brust_ready = r_ready;
   assign ack_err     = r_ack_err;
endmodule

// File: tb/tb_iic_wr_master.sv
// Bench for iic_wr_master: three instances (defaults, 27MHz/100kHz, fast QDIV=2)
// share one bus monitor/slave model selected by 'sel'.
module tb_iic_wr_master;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic send_en = 1'b0;
   logic [7:0] send_addr = 8'h00, send_data = 8'h00;
   logic brust_vaild = 1'b0;
   int sel = 0;
   logic pull = 1'b0;

   logic en0, en1, en2, busy0, busy1, busy2, rdy0, rdy1, rdy2, scl0, scl1, scl2;
   logic so0, so1, so2, oe0, oe1, oe2, si0, si1, si2, err0, err1, err2;
   logic scl_m, oe_m, busy_m, rdy_m, err_m;

   always #5 clk = ~clk;

   assign en0 = send_en && (sel == 0);
   assign en1 = send_en && (sel == 1);
   assign en2 = send_en && (sel == 2);
   assign si0 = ~oe0 & ~pull;
   assign si1 = ~oe1 & ~pull;
   assign si2 = ~oe2 & ~pull;

   iic_wr_master u_def (.clk(clk), .rst_n(rst_n), .send_en(en0), .send_addr(send_addr),
      .send_data(send_data), .send_busy(busy0), .brust_vaild(brust_vaild), .brust_ready(rdy0),
      .scl(scl0), .sda_o(so0), .sda_oe(oe0), .sda_i(si0), .ack_err(err0));
   iic_wr_master #(.CLK_FRE(27), .IIC_FREQ(100)) u_slow (.clk(clk), .rst_n(rst_n), .send_en(en1),
      .send_addr(send_addr), .send_data(send_data), .send_busy(busy1), .brust_vaild(brust_vaild),
      .brust_ready(rdy1), .scl(scl1), .sda_o(so1), .sda_oe(oe1), .sda_i(si1), .ack_err(err1));
   iic_wr_master #(.CLK_FRE(4), .IIC_FREQ(500)) u_fast (.clk(clk), .rst_n(rst_n), .send_en(en2),
      .send_addr(send_addr), .send_data(send_data), .send_busy(busy2), .brust_vaild(brust_vaild),
      .brust_ready(rdy2), .scl(scl2), .sda_o(so2), .sda_oe(oe2), .sda_i(si2), .ack_err(err2));

   always_comb begin
      scl_m = scl0; oe_m = oe0; busy_m = busy0; rdy_m = rdy0; err_m = err0;
      if (sel == 1) begin
         scl_m = scl1; oe_m = oe1; busy_m = busy1; rdy_m = rdy1; err_m = err1;
      end else if (sel == 2) begin
         scl_m = scl2; oe_m = oe2; busy_m = busy2; rdy_m = rdy2; err_m = err2;
      end
   end

   int n_chk = 0, n_fail = 0;
   int cyc = 0, nstart, nstop, rxn, bitcnt, last_fall, last_rise;
   int pmin, pmax, hmin, hmax, err_cnt, rdy_cnt, nack_byte = -1;
   logic [7:0] sh;
   logic [7:0] rx [0:255];
   logic prev_scl = 1'b1, prev_sda = 1'b1, s_now;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      nstart = 0; nstop = 0; rxn = 0; bitcnt = 0; last_fall = -1; last_rise = -1;
      pmin = 1 << 30; pmax = 0; hmin = 1 << 30; hmax = 0; err_cnt = 0; rdy_cnt = 0; pull = 1'b0;
   endtask

   // Bus decoder plus ACKing slave, sampled on the falling clock edge.
   initial begin
      clear_mon();
      forever begin
         @(negedge clk);
         cyc++;
         s_now = ~oe_m & ~pull;
         if (err_m) err_cnt++;
         if (rdy_m) rdy_cnt++;
         if (prev_scl && scl_m && prev_sda && !s_now) begin
            nstart++; bitcnt = 0; rxn = 0; last_fall = -1; last_rise = -1; pull = 1'b0;
         end else if (prev_scl && scl_m && !prev_sda && s_now) begin
            nstop++;
         end else if (!prev_scl && scl_m) begin
            last_rise = cyc;
            if (bitcnt < 8) begin
               sh = {sh[6:0], s_now};
               bitcnt++;
               if (bitcnt == 8 && rxn < 256) begin
                  rx[rxn] = sh;
                  rxn++;
               end
            end else bitcnt = 0;
         end else if (prev_scl && !scl_m) begin
            if (last_fall >= 0) begin
               if (cyc - last_fall < pmin) pmin = cyc - last_fall;
               if (cyc - last_fall > pmax) pmax = cyc - last_fall;
            end
            last_fall = cyc;
            if (last_rise >= 0) begin
               if (cyc - last_rise < hmin) hmin = cyc - last_rise;
               if (cyc - last_rise > hmax) hmax = cyc - last_rise;
            end
            last_rise = -1;
            pull = (bitcnt == 8) && ((rxn - 1) != nack_byte);
         end
         prev_scl = scl_m;
         prev_sda = ~oe_m & ~pull;
      end
   end

   typedef struct {
      int sel; logic [7:0] addr; logic [7:0] data; int nburst; int nack; int mid;
      int busy; int nbytes; int rdy; int err; int pmin; int pmax; int high;
   } rec_t;
   rec_t recs [7];

   task automatic run_rec(input int id, input rec_t r);
      int busy_cnt, pulses;
      bit done;
      logic [7:0] exp_b;
      sel = r.sel; nack_byte = r.nack;
      send_addr = r.addr; send_data = r.data; brust_vaild = (r.nburst > 0);
      @(negedge clk); #1;
      clear_mon();
      chk($sformatf("r%0d busy_before_en", id), int'(busy_m), 0);
      send_en = 1'b1;
      @(negedge clk); #1;
      send_en = 1'b0;
      chk($sformatf("r%0d busy_after_en", id), int'(busy_m), 1);
      busy_cnt = 1; pulses = 0; done = 1'b0;
      for (int k = 0; k < 20000 && !done; k++) begin
         if (rdy_m) begin
            pulses++;
            if (pulses <= r.nburst) send_data = r.data + 8'(pulses);
            else brust_vaild = 1'b0;
         end
         send_en = (r.mid > 0) && (k == r.mid);
         if (send_en) send_data = 8'hFF;
         @(negedge clk); #1;
         if (busy_m) busy_cnt++;
         else done = 1'b1;
      end
      send_en = 1'b0; brust_vaild = 1'b0;
      chk($sformatf("r%0d frame_done_in_time", id), int'(done), 1);
      repeat (8) @(negedge clk);
      #1;
      chk($sformatf("r%0d busy_cycles", id), busy_cnt, r.busy);
      chk($sformatf("r%0d byte_count", id), rxn, r.nbytes);
      for (int i = 0; i < r.nbytes && i < rxn; i++) begin
         if (i == 0) exp_b = 8'h78;
         else if (i == 1) exp_b = r.addr;
         else exp_b = r.data + 8'(i - 2);
         chk($sformatf("r%0d byte%0d", id, i), int'(rx[i]), int'(exp_b));
      end
      chk($sformatf("r%0d starts", id), nstart, 1);
      chk($sformatf("r%0d stops", id), nstop, 1);
      chk($sformatf("r%0d ready_pulses", id), rdy_cnt, r.rdy);
      chk($sformatf("r%0d ack_err_cycles", id), err_cnt, r.err);
      chk($sformatf("r%0d scl_period_min", id), pmin, r.pmin);
      chk($sformatf("r%0d scl_period_max", id), pmax, r.pmax);
      chk($sformatf("r%0d scl_high_min", id), hmin, r.high);
      chk($sformatf("r%0d scl_high_max", id), hmax, r.high);
      chk($sformatf("r%0d busy_after_frame", id), int'(busy_m), 0);
   endtask

   initial begin
      rec_t rr;
      bit hit;
      //         sel addr   data  nbur nack mid  busy  nbyt rdy err pmin pmax high
      recs[0] = '{0, 8'h00, 8'hAE,   0,  -1,   0, 3503,   3,   0, 0, 124, 124,  62};
      recs[1] = '{2, 8'h40, 8'h01, 128,  -1,   0, 9829, 131, 129, 0,   8,  11,   4};
      recs[2] = '{0, 8'h00, 8'hAE,   0,   0,   0, 1271,   1,   0, 1, 124, 124,  62};
      recs[3] = '{0, 8'h40, 8'h3C,   0,  -1, 500, 3503,   3,   0, 0, 124, 124,  62};
      recs[4] = '{1, 8'h00, 8'hA5,   0,  -1,   0, 7571,   3,   0, 0, 268, 268, 134};
      recs[5] = '{0, 8'h40, 8'h96,   3,   2,   0, 3503,   3,   0, 1, 124, 124,  62};
      recs[6] = '{2, 8'h00, 8'hC3,   2,  -1,   0,  379,   5,   3, 0,   8,  11,   4};

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset scl", int'(scl0), 1);
      chk("reset sda_oe", int'(oe0), 0);
      chk("reset sda_o", int'(so0), 0);
      chk("reset busy", int'(busy0), 0);
      chk("reset ready", int'(rdy0), 0);
      chk("reset ack_err", int'(err0), 0);
      chk("reset scl slow", int'(scl1), 1);
      chk("reset scl fast", int'(scl2), 1);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 7; i++) run_rec(i, recs[i]);

      // Reset in the middle of a burst, during the low phase of a data bit.
      sel = 2; nack_byte = -1; send_addr = 8'h40; send_data = 8'h01; brust_vaild = 1'b1;
      @(negedge clk); #1;
      clear_mon();
      send_en = 1'b1;
      @(negedge clk); #1;
      send_en = 1'b0;
      hit = 1'b0;
      for (int k = 0; k < 2000 && !hit; k++) begin
         @(negedge clk); #1;
         if (rxn == 3 && bitcnt == 3 && !scl_m) hit = 1'b1;
      end
      chk("rst_mid reached_bit3", int'(hit), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid scl", int'(scl2), 1);
      chk("rst_mid sda_oe", int'(oe2), 0);
      chk("rst_mid busy", int'(busy2), 0);
      chk("rst_mid ready", int'(rdy2), 0);
      @(negedge clk);
      rst_n = 1'b1; brust_vaild = 1'b0;
      repeat (3) @(negedge clk);
      rr = '{2, 8'h00, 8'h5A, 0, -1, 0, 226, 3, 0, 0, 8, 8, 4};
      run_rec(7, rr);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/iic_wr_master.md
# iic_wr_master

Write-only I2C master that sits between the OLED controller and the SSD1306 pins. It turns single-byte requests (`send_en`/`send_addr`/`send_data`) and streamed bursts (`brust_vaild`/`brust_ready`) into I2C write frames of the form START, device address + W, control byte, one or more data bytes, STOP. SCL is push-pull. SDA is open-drain and splits into output, enable and input; the top-level tristate is built outside this block.

## Interface
Parameters:
- `CLK_FRE`, 50: system clock in MHz.
- `IIC_FREQ`, 400: SCL frequency in kHz.
- `DEV_ADDR`, 7'h3C: 7-bit slave address.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset. One clock; reset is asynchronous and active-low.
- `send_en`  in  1: start a frame. Accepted only in IDLE.
- `send_addr`  in  8: control byte (8'h00 = command, 8'h40 = data).
- `send_data`  in  8: first data byte.
- `send_busy`  out  1: frame in progress.
- `brust_vaild`  in  1: requester wants more data bytes in the current frame.
- `brust_ready`  out  1: one-cycle request for the next burst byte.
- `scl`  out  1: I2C clock.
- `sda_o`  out  1: held at 0 (open-drain value).
- `sda_oe`  out  1: 1 pulls SDA low, 0 releases it.
- `sda_i`  in  1: SDA pin level.
- `ack_err`  out  1: one-cycle pulse when a NACK is detected.

## Operation
- Quarter-bit tick: QDIV = CLK_FRE*1000/(IIC_FREQ*4), truncated (31 at the defaults).
  - A counter counts 0..QDIV-1 and ticks when it wraps.
  - The counter runs only outside IDLE and clears on entry to START.
- Bit timing: one bit = 4 quarters, q0..q3.
  - q0–q1: SCL low. SDA is updated at the start of q0.
  - q2–q3: SCL high.
- States:
  - IDLE: `scl`=1, SDA released. If `send_en`=1, latch `send_addr`/`send_data` into a 3-byte frame buffer {DEV_ADDR,1'b0}, addr, data. Set byte index = 0. Go to START.
  - START: 2 quarters. Q0: SCL high, SDA released. Q1: SCL high, SDA low. Then SHIFT.
  - SHIFT: 8 bits of the current byte, MSB first. A 1 releases SDA; a 0 drives it low.
  - ACK: 9th bit with SDA released. `sda_i` is sampled on the first cycle of q3.
    - `sda_i`=1: pulse `ack_err`, go to STOP.
    - Byte index < 2: increment the index, go to SHIFT.
    - Byte index ≥ 2 and `brust_vaild`=1: go to REQ.
    - Byte index ≥ 2 and `brust_vaild`=0: go to STOP.
  - REQ: `brust_ready`=1 for exactly one cycle (cycle T). At cycle T+2, sample `brust_vaild`.
    - `brust_vaild`=1: latch `send_data` as the next byte, go to SHIFT.
    - `brust_vaild`=0: go to STOP; nothing is transmitted.
  - STOP: 3 quarters. SCL low / SDA low, then SCL high / SDA low, then SCL high / SDA released. Then IDLE.
- `send_busy` = 1 in every state except IDLE.
- Burst length is unbounded; the byte index saturates at 2.

## Timing
- Reset values, applied immediately: state IDLE, `scl`=1, `sda_oe`=0, `sda_o`=0, `send_busy`=0, `brust_ready`=0, `ack_err`=0, counters 0.
- Reset asserted mid-frame releases the bus at once. No STOP is generated.
- `send_en` sampled at edge E sets `send_busy`=1 from E+1. The requester sees busy on the cycle after it pulses `send_en`.
- `send_en` while busy is ignored; it is not queued.
- `send_en` on the same cycle STOP finishes is ignored. It is accepted from the first IDLE cycle.
- Byte time = 36*QDIV clk. Three-byte frame = (2+108+3)*QDIV clk = 3503 clk at the defaults.
- REQ adds 3 clk between the ACK bit and the next data bit's q0.
- `brust_ready` never asserts outside REQ. It never asserts after a NACK.
- SDA changes only while SCL is low, except for the START and STOP edges.

## Test plan
- Single command: `send_en` with addr 8'h00, data 8'hAE, slave always ACKs.
  - Expect a decoded frame 78,00,AE, one START, one STOP.
  - `send_busy` high 3503 clk.
  - `brust_ready` never asserted.
- Burst of 129 data bytes: `send_en` with addr 8'h40, data 8'h01; `brust_vaild`=1; requester supplies 8'h02.. on each `brust_ready`; `brust_vaild` drops after the 128th `brust_ready` pulse.
  - Expect 78,40 followed by 129 data bytes.
  - Expect exactly 129 `brust_ready` pulses: the last one is answered with `brust_vaild` low, followed by STOP.
- NACK on address: slave leaves SDA high at the first ACK.
  - Expect a one-cycle `ack_err` pulse, immediate STOP, no control byte on the bus.
  - `send_busy` falls after the STOP.
- `send_en` pulsed mid-frame with data 8'hFF.
  - Expect it ignored: frame bytes unchanged and no second frame.
- Reset mid-burst: assert `rst_n`=0 during data bit 3.
  - Expect `scl`=1, `sda_oe`=0, `send_busy`=0 in the same cycle.
  - A new `send_en` after release produces a clean frame.
- Parameter sweep: CLK_FRE=27, IIC_FREQ=100 (QDIV=67).
  - Expect an SCL period of 268 clk, 50% duty.
  - START/STOP checked for SDA transitions while SCL is high.
